md_unit: RTL and testbench

Multi-cycle multiply/divide unit for the E stage of the five-stage pipeline. The E-stage control decode drives it with an operation code, and it owns the architectural HI/LO registers. Its `busy` output is consumed by the D-stage hazard logic, which stalls any multiply/divide-class instruction while an operation is in flight. It models fixed MIPS multiply and divide latencies with a cycle counter and commits results to HI/LO only on completion.

---
 rtl/md_unit_pkg.sv | 38 +++
 rtl/md_unit.sv | 170 +++++++++++++++++
 tb/tb_md_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg
//
// Purpose: shared operation codes and state encoding for the multiply/divide
// unit. The E-stage control decode imports the same MDOp constants so both
// sides of the interface agree on the encoding.
//
// Contents:
//   md_op_e     - 3-bit multiply/divide operation code (7 is reserved, acts as NONE)
//   md_state_e  - IDLE / RUN state of the latency model
//   MD_DIV_MIN  - most negative 32-bit dividend, used for the DIV overflow case
//   MD_NEG_ONE  - all-ones divisor, used for the DIV overflow case
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam logic [31:0] MD_DIV_MIN = 32'h8000_0000;
  localparam logic [31:0] MD_NEG_ONE = 32'hFFFF_FFFF;

  // True for the ops that occupy the unit for a fixed number of cycles.
  function automatic logic isLongOp(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit
//
// Purpose: multi-cycle multiply/divide unit for the E stage. It owns the
// architectural HI/LO registers. A multiply or divide computes its result at
// the start edge into pending registers, then a down-counter models the fixed
// MIPS latency; HI/LO are only written on the edge the counter reaches zero.
// mthi/mtlo write HI/LO directly in a single cycle.
//
// Parameters:
//   MULT_CYCLES - start-to-commit latency of mult/multu (>= 1)
//   DIV_CYCLES  - start-to-commit latency of div/divu (>= 1)
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-high reset, clears all state
//   start  in   1   E-stage instruction is a multiply/divide-class op
//   MDOp   in   3   operation code (md_op_e)
//   A      in  32   forwarded rs value
//   B      in  32   forwarded rt value
//   busy   out  1   operation in flight, registered
//   HI     out 32   architectural HI register
//   LO     out 32   architectural LO register
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     hiPend_q, hiPend_d;
  logic [31:0]     loPend_q, loPend_d;

  md_op_e          op;
  logic [63:0]     prod;
  logic [31:0]     resHi;
  logic [31:0]     resLo;

  assign op = md_op_e'(MDOp);

  // Result datapath, evaluated from the current A/B so it can be captured
  // into the pending registers on the start edge. A zero divisor yields the
  // current HI/LO, so the later commit leaves them unchanged without needing
  // a separate "commit enable" flag. The most-negative / -1 divide is pinned
  // explicitly because the 32-bit signed quotient overflows.
  always_comb begin
    prod  = '0;
    resHi = hi_q;
    resLo = lo_q;
    case (op)
      MD_MULT: begin
        prod  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        resHi = prod[63:32];
        resLo = prod[31:0];
      end
      MD_MULTU: begin
        prod  = {32'b0, A} * {32'b0, B};
        resHi = prod[63:32];
        resLo = prod[31:0];
      end
      MD_DIV: begin
        if (B == 32'b0) begin
          resHi = hi_q;
          resLo = lo_q;
        end else if ((A == MD_DIV_MIN) && (B == MD_NEG_ONE)) begin
          resHi = 32'b0;
          resLo = MD_DIV_MIN;
        end else begin
          resLo = $signed(A) / $signed(B);
          resHi = $signed(A) % $signed(B);
        end
      end
      MD_DIVU: begin
        if (B != 32'b0) begin
          resLo = A / B;
          resHi = A % B;
        end
      end
      default: begin
        prod  = '0;
      end
    endcase
  end

  // Next-state logic. In IDLE a qualified long op captures its result and
  // loads the latency counter; mthi/mtlo write straight through. In RUN every
  // input is ignored and the counter runs down, committing on 1 -> 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hiPend_d = hiPend_q;
    loPend_d = loPend_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (isLongOp(op)) begin
            hiPend_d = resHi;
            loPend_d = resLo;
            cnt_d    = ((op == MD_MULT) || (op == MD_MULTU)) ? MultLoad : DivLoad;
            state_d  = MD_RUN;
          end else if (op == MD_MTHI) begin
            hi_d = A;
          end else if (op == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          hi_d    = hiPend_q;
          lo_d    = loPend_q;
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, pending and architectural registers. Reset discards any
  // in-flight result and zeroes HI/LO immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hiPend_q <= '0;
      loPend_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hiPend_q <= hiPend_d;
      loPend_q <= loPend_d;
    end
  end

  // busy comes straight from the state flop so it never glitches on start.
  assign busy = (state_q == MD_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit
//
// Directed bench for md_unit: a table of operations with hand-computed
// HI/LO results applied in sequence, followed by hand-written sequences for
// start-while-busy, start at the completion edge, and asynchronous reset.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  logic [31:0] curHi;
  logic [31:0] curLo;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[14];

  md_unit #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .MDOp (MDOp),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, want %08h", name, actual, expected);
    end
  endtask

  // Drives one op for a single edge, then checks busy and HI/LO stability
  // through every busy cycle, then the committed result. Caller is #1 after
  // an edge on entry; returns #1 after the commit edge.
  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int cycles,
                               input logic [31:0] expHi, input logic [31:0] expLo);
    start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    MDOp  = MD_NONE;
    for (int i = 0; i < cycles; i++) begin
      checkOutput({name, " busy"}, {31'b0, busy}, 32'd1);
      checkOutput({name, " hold HI"}, HI, curHi);
      checkOutput({name, " hold LO"}, LO, curLo);
      @(posedge clk);
      #1;
    end
    checkOutput({name, " done busy"}, {31'b0, busy}, 32'd0);
    checkOutput({name, " HI"}, HI, expHi);
    checkOutput({name, " LO"}, LO, expLo);
    curHi = expHi;
    curLo = expLo;
  endtask

  initial begin
    vecs[0]  = '{"mult neg",    MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, MultN, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{"multu max",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MultN, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{"div neg",     MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, DivN,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"divu by0",    MD_DIVU,  32'h0000_0007, 32'h0000_0000, DivN,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{"mthi",        MD_MTHI,  32'h1234_5678, 32'h0000_0000, 0,     32'h1234_5678, 32'hFFFF_FFFD};
    vecs[5]  = '{"mtlo",        MD_MTLO,  32'h9ABC_DEF0, 32'h0000_0000, 0,     32'h1234_5678, 32'h9ABC_DEF0};
    vecs[6]  = '{"div ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DivN,  32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{"divu 16",     MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, DivN,  32'h0000_000F, 32'h0FFF_FFFF};
    vecs[8]  = '{"mult minsq",  MD_MULT,  32'h8000_0000, 32'h8000_0000, MultN, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{"div negdvs",  MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, DivN,  32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{"none op",     MD_NONE,  32'hAAAA_AAAA, 32'h5555_5555, 0,     32'h0000_0001, 32'hFFFF_FFFD};
    vecs[11] = '{"rsvd op",     MD_RSVD,  32'hAAAA_AAAA, 32'h5555_5555, 0,     32'h0000_0001, 32'hFFFF_FFFD};
    vecs[12] = '{"mult m1",     MD_MULT,  32'h0001_2345, 32'hFFFF_FFFF, MultN, 32'hFFFF_FFFF, 32'hFFFE_DCBB};
    vecs[13] = '{"div by0",     MD_DIV,   32'h8000_0000, 32'h0000_0000, DivN,  32'hFFFF_FFFF, 32'hFFFE_DCBB};

    reset = 1'b1;
    start = 1'b0;
    MDOp  = MD_NONE;
    A     = '0;
    B     = '0;
    curHi = '0;
    curLo = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset HI", HI, 32'd0);
    checkOutput("reset LO", LO, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].name, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].cycles,
                    vecs[v].expHi, vecs[v].expLo);
    end

    // Start during RUN is ignored, start on the commit edge is ignored,
    // and the same request one edge later is accepted.
    start = 1'b1;
    MDOp  = MD_DIV;
    A     = 32'd100;
    B     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    MDOp  = MD_NONE;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    MDOp  = MD_MTLO;
    A     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    MDOp  = MD_NONE;
    checkOutput("busy mtlo busy", {31'b0, busy}, 32'd1);
    checkOutput("busy mtlo LO", LO, curLo);
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1;
    MDOp  = MD_MTHI;
    A     = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    checkOutput("commit edge busy", {31'b0, busy}, 32'd0);
    checkOutput("commit edge HI", HI, 32'h0000_0002);
    checkOutput("commit edge LO", LO, 32'h0000_000E);
    @(posedge clk);
    #1;
    start = 1'b0;
    MDOp  = MD_NONE;
    checkOutput("late mthi busy", {31'b0, busy}, 32'd0);
    checkOutput("late mthi HI", HI, 32'hCAFE_F00D);
    checkOutput("late mthi LO", LO, 32'h0000_000E);

    // Asynchronous reset in the middle of the second busy cycle.
    start = 1'b1;
    MDOp  = MD_MULT;
    A     = 32'd3;
    B     = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    MDOp  = MD_NONE;
    @(posedge clk);
    #2;
    checkOutput("pre reset busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("async reset busy", {31'b0, busy}, 32'd0);
    checkOutput("async reset HI", HI, 32'd0);
    checkOutput("async reset LO", LO, 32'd0);
    #2;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("post reset busy", {31'b0, busy}, 32'd0);
    checkOutput("post reset HI", HI, 32'd0);
    checkOutput("post reset LO", LO, 32'd0);
    curHi = '0;
    curLo = '0;
    applyStimulus("mult after reset", MD_MULT, 32'd3, 32'd5, MultN, 32'd0, 32'h0000_000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
